// File: rtl/ws2812_frame_scheduler.sv
// ws2812_frame_scheduler
//   Paces whole-frame transfers to the ws2812_output serializer. A free-running
//   period counter produces a tick every FRAME_CYCLES clocks. A tick seen in WAIT
//   with enable high starts a frame: the first byte is prefetched from the
//   double-buffered pixel RAM, ws_trigger fires, and each serializer byte request
//   launches the fetch of the next byte. Bank ownership swaps with the producer
//   only at frame start, and only when frame_ready is high.
//
//   Optional feature macro: GLOBAL_DIM_EN
//     adds input dim[7:0]. It is sampled at frame start and held for the frame.
//     ws_byte = (mem_rdata * (dim + 1)) >> 8, in the same register stage.
//
// Ports
//   CLK, rst_n          clock; asynchronous active-low reset
//   enable              allow new frames to start at a tick
//   frame_ready         producer has filled the back bank (level)
//   frame_ack           1-cycle pulse: swap taken
//   bank_sel            bank being displayed (the producer owns ~bank_sel)
//   mem_addr/mem_rdata  byte index into displayed bank / read data one cycle later
//   ws_trigger          1-cycle pulse starting a serializer frame
//   ws_data_request     serializer captures ws_byte in this cycle
//   ws_byte             byte presented to the serializer
//   frame_done          1-cycle pulse after the last byte is captured
//   frame_count         completed frames (wraps)
//   underrun            sticky: a request arrived while a fetch was pending
//   busy                state is not WAIT
module ws2812_frame_scheduler #(
  parameter int LEDS         = 40,
  parameter int FRAME_CYCLES = 1200000,
  parameter int ADDR_W       = $clog2(LEDS*3)
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              frame_ready,
  output logic              frame_ack,
  output logic              bank_sel,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              ws_trigger,
  input  logic              ws_data_request,
  output logic [7:0]        ws_byte,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              underrun,
`ifdef GLOBAL_DIM_EN
  input  logic [7:0]        dim,
`endif
  output logic              busy
);

  localparam int NBYTES = LEDS * 3;
  localparam int CNT_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NBYTES - 1);

  typedef enum logic [1:0] {S_WAIT = 2'd0, S_FETCH = 2'd1, S_STREAM = 2'd2} state_t;

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_fetch;   // 2: address presented, 1: read data arriving, 0: idle
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_byte;
  logic [15:0]       r_count;
  logic              r_bank, r_ack, r_trig, r_done, r_unr;
  logic              w_tick, w_pending, w_load;
  logic              w_start, w_adv, w_last, w_unr;
  logic [7:0]        w_byte_nxt;

  assign w_tick    = (r_cnt == '0);
  assign w_pending = (r_fetch != 2'd0);
  assign w_load    = (r_fetch == 2'd1);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) r_state <= S_WAIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_adv   = 1'b0;
    w_last  = 1'b0;
    w_unr   = 1'b0;
    case (r_state)
      S_WAIT: if (w_tick && enable) begin
        w_start = 1'b1;
        w_next  = S_FETCH;
      end
      // Leave once the first byte lands in ws_byte; the trigger is registered
      // so it coincides with that byte becoming valid.
      S_FETCH: if (w_load) w_next = S_STREAM;
      S_STREAM: if (ws_data_request) begin
        if (w_pending)                w_unr  = 1'b1;
        else if (r_addr == LAST_ADDR) begin
          w_last = 1'b1;
          w_next = S_WAIT;
        end else                      w_adv  = 1'b1;
      end
      default: w_next = S_WAIT;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= CNT_MAX;
      r_fetch <= 2'd0;
      r_addr  <= '0;
      r_byte  <= 8'h00;
      r_count <= 16'h0000;
      r_bank  <= 1'b0;
      r_ack   <= 1'b0;
      r_trig  <= 1'b0;
      r_done  <= 1'b0;
      r_unr   <= 1'b0;
    end else begin
      r_cnt  <= w_tick ? CNT_MAX : r_cnt - CNT_W'(1);
      r_ack  <= w_start & frame_ready;
      r_trig <= (r_state == S_FETCH) & w_load;
      r_done <= w_last;
      if (w_start && frame_ready) r_bank <= ~r_bank;
      if (w_start) begin
        r_addr  <= '0;
        r_fetch <= 2'd2;
      end else if (w_adv) begin
        r_addr  <= r_addr + ADDR_W'(1);
        r_fetch <= 2'd2;
      end else if (w_pending) begin
        r_fetch <= r_fetch - 2'd1;
      end
      if (w_load) r_byte  <= w_byte_nxt;
      if (w_last) r_count <= r_count + 16'd1;
      if (w_unr)  r_unr   <= 1'b1;
    end
  end

`ifdef GLOBAL_DIM_EN
  logic [7:0]  r_dim;
  logic [15:0] w_prod;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)       r_dim <= 8'h00;
    else if (w_start) r_dim <= dim;
  end

  // rdata*(dim+1) never exceeds 255*256, so 16 bits hold it exactly.
  assign w_prod     = 16'(mem_rdata) * 16'(r_dim) + 16'(mem_rdata);
  assign w_byte_nxt = 8'(w_prod >> 8);
`else
  assign w_byte_nxt = mem_rdata;
`endif

  assign frame_ack   = r_ack;
  assign bank_sel    = r_bank;
  assign mem_addr    = r_addr;
  assign ws_trigger  = r_trig;
  assign ws_byte     = r_byte;
  assign frame_done  = r_done;
  assign frame_count = r_count;
  assign underrun    = r_unr;
  assign busy        = (r_state != S_WAIT);

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Testbench for ws2812_frame_scheduler. A cycle-stepped driver holds a
// frame-level reference model: ticks every FC cycles from reset, one frame per
// accepted tick, a frame occupies the scheduler until its last byte request.
// Expected events go into queues. A negedge monitor pops and compares them.
module tb_ws2812_frame_scheduler;
  localparam int LEDS = 4;
  localparam int FC   = 200;
  localparam int NB   = LEDS * 3;
  localparam int AW   = $clog2(NB);

  logic          CLK = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0, frame_ready = 1'b0, ws_data_request = 1'b0;
  logic          frame_ack, bank_sel, ws_trigger, frame_done, underrun, busy;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata = 8'h00, ws_byte;
  logic [15:0]   frame_count;
`ifdef GLOBAL_DIM_EN
  logic [7:0]    dim = 8'hFF;
`endif

  always #5 CLK = ~CLK;

  ws2812_frame_scheduler #(.LEDS(LEDS), .FRAME_CYCLES(FC), .ADDR_W(AW)) dut (
    .CLK(CLK), .rst_n(rst_n), .enable(enable), .frame_ready(frame_ready),
    .frame_ack(frame_ack), .bank_sel(bank_sel), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .ws_trigger(ws_trigger),
    .ws_data_request(ws_data_request), .ws_byte(ws_byte),
    .frame_done(frame_done), .frame_count(frame_count), .underrun(underrun),
`ifdef GLOBAL_DIM_EN
    .dim(dim),
`endif
    .busy(busy));

  // Pixel RAM: synchronous read, data valid the cycle after the address.
  logic [7:0] ram [2][NB];
  always @(posedge CLK)
    mem_rdata <= (mem_addr < AW'(NB)) ? ram[bank_sel][mem_addr] : 8'h00;

  // Scoreboard queues
  int         q_trig_cyc[$];
  bit         q_trig_bank[$];
  int         q_ack[$];
  logic [7:0] q_byte[$];
  int         q_done_cyc[$];
  int         q_done_cnt[$];
  bit         q_done_unr[$];

  int errs = 0, checks = 0;
  int n;                       // cycle number since reset release
  bit tb_cap, exp_busy;
  // model state
  bit m_busy, m_bank, m_unr;
  int m_start, m_next_req, m_last_req, m_nreq, m_inj_at, m_cnt;
  // stimulus configuration
  bit c_en, c_fr, c_inj;
  int c_gap_lo, c_gap_hi;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errs++;
    $display("FAIL %s: got a pulse, expected none (cycle %0d)", name, n);
  endtask

  function automatic logic [7:0] exp_byte(input logic [7:0] b);
`ifdef GLOBAL_DIM_EN
    int p;
    p = int'(b) * (int'(dim) + 1);
    return 8'(p / 256);
`else
    return b;
`endif
  endfunction

  task automatic apply_reset(input int hold);
    rst_n = 1'b0; ws_data_request = 1'b0; tb_cap = 1'b0;
    #1;
    chk("rst_busy", busy, 0);           chk("rst_bank_sel", bank_sel, 0);
    chk("rst_mem_addr", mem_addr, 0);   chk("rst_ws_byte", ws_byte, 0);
    chk("rst_frame_count", frame_count, 0); chk("rst_underrun", underrun, 0);
    chk("rst_frame_ack", frame_ack, 0); chk("rst_ws_trigger", ws_trigger, 0);
    chk("rst_frame_done", frame_done, 0);
    q_trig_cyc.delete(); q_trig_bank.delete(); q_ack.delete(); q_byte.delete();
    q_done_cyc.delete(); q_done_cnt.delete(); q_done_unr.delete();
    m_busy = 0; m_bank = 0; m_unr = 0; m_cnt = 0; m_start = -1; m_inj_at = -1;
    m_nreq = 0; m_next_req = -1; m_last_req = 32'h7fffffff; exp_busy = 0;
    repeat (hold) @(posedge CLK);
    #1;
    rst_n = 1'b1; n = 0; enable = c_en; frame_ready = c_fr;
  endtask

  // One clock of stimulus plus the reference model for that cycle.
  task automatic step();
    @(posedge CLK); #1;
    n++;
    ws_data_request = 1'b0; tb_cap = 1'b0;
    if (m_busy && n > m_last_req) begin
      m_busy = 0;
      for (int i = 0; i < NB; i++) ram[!m_bank][i] = 8'($urandom);
    end
`ifdef GLOBAL_DIM_EN
    case ($urandom_range(0, 2))
      0:       dim = 8'h7F;
      1:       dim = 8'hFF;
      default: dim = 8'($urandom);
    endcase
`endif
    enable = c_en; frame_ready = c_fr;
    if ((n % FC) == FC - 1 && c_en && !m_busy) begin
      if (c_fr) begin
        m_bank = !m_bank;
        q_ack.push_back(n + 1);
      end
      q_trig_cyc.push_back(n + 3);
      q_trig_bank.push_back(m_bank);
      for (int i = 0; i < NB; i++) q_byte.push_back(exp_byte(ram[m_bank][i]));
      m_busy = 1; m_start = n; m_nreq = 0;
      m_next_req = n + 3 + $urandom_range(0, 3);
      m_last_req = 32'h7fffffff;
    end
    if (m_busy && n == m_next_req) begin
      ws_data_request = 1'b1; tb_cap = 1'b1; m_nreq++;
      if (m_nreq == NB) begin
        m_last_req = n; m_cnt++;
        q_done_cyc.push_back(n + 1);
        q_done_cnt.push_back(m_cnt & 16'hFFFF);
        q_done_unr.push_back(m_unr);
      end else begin
        m_next_req = n + $urandom_range(c_gap_lo, c_gap_hi);
        if (c_inj && m_nreq == 4) begin m_inj_at = n + 1; c_inj = 0; end
      end
    end else if (n == m_inj_at) begin
      ws_data_request = 1'b1; m_unr = 1; m_inj_at = -1;
    end
    exp_busy = m_busy && (n > m_start);
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Monitor
  always @(negedge CLK) begin
    if (rst_n) begin
      chk("busy", busy, exp_busy);
      if (ws_trigger) begin
        if (q_trig_cyc.size() == 0) unexpected("ws_trigger");
        else begin
          chk("trigger_cycle", n, q_trig_cyc.pop_front());
          chk("trigger_bank_sel", bank_sel, q_trig_bank.pop_front());
        end
      end
      if (frame_ack) begin
        if (q_ack.size() == 0) unexpected("frame_ack");
        else chk("ack_cycle", n, q_ack.pop_front());
      end
      if (ws_data_request && tb_cap) begin
        if (q_byte.size() == 0) unexpected("byte_capture");
        else chk("ws_byte", ws_byte, q_byte.pop_front());
      end
      if (frame_done) begin
        if (q_done_cyc.size() == 0) unexpected("frame_done");
        else begin
          chk("done_cycle", n, q_done_cyc.pop_front());
          chk("frame_count", frame_count, q_done_cnt.pop_front());
          chk("underrun_at_done", underrun, q_done_unr.pop_front());
        end
      end
    end
  end

  initial begin
    c_en = 1; c_fr = 0; c_inj = 0; c_gap_lo = 8; c_gap_hi = 8;
    for (int i = 0; i < NB; i++) begin
      ram[0][i] = 8'(8'h10 + i);
      ram[1][i] = 8'($urandom);
    end
    #2;
    apply_reset(3);
    run(300);                          // frame 1 from bank 0: 0x10..0x1B
    c_fr = 1; run(200); c_fr = 0;      // swap at 2nd tick
    c_inj = 1; c_gap_lo = 4; run(200); // 3rd tick: no swap, one underrun
    c_gap_lo = 20; c_gap_hi = 20;
    run(400);                          // long stream: tick at 999 skipped
    c_gap_lo = 4; c_gap_hi = 8;
    run(120);                          // frame 5 starts, mid-stream
    c_en = 0; run(480);                // finishes, no later triggers
    c_en = 1; run(130);                // frame 6 mid-stream
    apply_reset(3);                    // no frame_done, everything cleared
    run(300);                          // clean frame after reset
    chk("trig_left", q_trig_cyc.size(), 0);
    chk("ack_left", q_ack.size(), 0);
    chk("bytes_left", q_byte.size(), 0);
    chk("done_left", q_done_cyc.size(), 0);
    chk("frame_count_final", frame_count, m_cnt);
    chk("bank_sel_final", bank_sel, m_bank);
    chk("underrun_final", underrun, m_unr);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ws2812_frame_scheduler.md
Name: ws2812_frame_scheduler

Overview:
Sequences whole-frame transfers to the ws2812_output serializer: paces frames on a fixed period, fires its trigger, and answers each byte request from a double-buffered pixel RAM (1-cycle synchronous read). Arbitrates bank ownership between the display side and a pixel producer (fader/animation logic) via a frame_ready/frame_ack swap handshake at frame boundaries.

Parameters:
LEDS, 40, number of LEDs in the chain; bytes per frame NBYTES = LEDS*3, ordered G,R,B per LED.
FRAME_CYCLES, 1200000, frame period in CLK cycles; must exceed worst-case stream time.
ADDR_W, $clog2(LEDS*3), byte index width.

Ports:
CLK  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
enable  in  1  allow new frames to start
frame_ready  in  1  level; producer has finished filling the back bank
frame_ack  out  1  1-cycle pulse; swap taken, producer now owns the other bank
bank_sel  out  1  bank currently displayed; producer writes ~bank_sel
mem_addr  out  ADDR_W  byte index into displayed bank
mem_rdata  in  8  read data, valid the cycle after mem_addr
ws_trigger  out  1  1-cycle pulse starting a serializer frame
ws_data_request  in  1  1-cycle pulse; serializer captures ws_byte this cycle
ws_byte  out  8  byte presented to serializer
frame_done  out  1  1-cycle pulse after last byte captured
frame_count  out  16  completed frames, wraps at 0xFFFF->0
underrun  out  1  sticky; request arrived while fetch pending
busy  out  1  high in any state other than WAIT

Behaviour:
- Reset (async, rst_n=0): state WAIT; period counter=FRAME_CYCLES-1; bank_sel=0, mem_addr=0, ws_byte=0, frame_count=0; all pulses, underrun and busy 0.
- Period counter: free-running down-counter, reloads FRAME_CYCLES-1 on reaching 0; runs in all states. Tick = counter==0.
- WAIT: on tick && enable -> FETCH. Same cycle: if frame_ready, toggle bank_sel and pulse frame_ack (next cycle). Tick while not in WAIT (overrun) -> frame skipped, no trigger, no ack.
- FETCH: cycle F: mem_addr=0, byte_idx=0. F+1: ws_byte<=mem_rdata. F+2: ws_byte valid, ws_trigger=1 for one cycle -> STREAM.
- STREAM: on ws_data_request with no fetch pending:
  - byte_idx<NBYTES-1: byte_idx+1 and mem_addr=byte_idx+1 next cycle; ws_byte updated 2 cycles after request (fetch pending for those 2 cycles).
  - byte_idx==NBYTES-1: frame_done pulse next cycle, frame_count+1, -> WAIT; ws_byte holds last value.
- Request during pending fetch: ignored (no advance), underrun set; serializer guarantees >=4 cycles between requests, so this is a fault indicator only.
- ws_data_request in WAIT/FETCH: ignored, no flag.
- enable low mid-frame: current frame completes; no further frames.
- frame_ready dropping before a tick: no swap. frame_ready held high: one swap per started frame.
- Reset mid-frame: immediate return to reset values; no frame_done; serializer must be reset alongside.

Optional Feature:
GLOBAL_DIM_EN: adds input port dim [7:0], sampled at frame start (FETCH entry) and held for the frame; ws_byte = (mem_rdata*(dim+1))>>8, registered in the same stage, latency unchanged; dim=255 is identity. Without the macro: no dim port, ws_byte = mem_rdata.

Test Plan:
- LEDS=4, FRAME_CYCLES=200, enable=1, RAM bank0 bytes 0x10..0x1B, serializer model requesting every 8 cycles -> one trigger per 200 cycles, 12 bytes captured in order 0x10..0x1B, frame_done once, frame_count=1.
- frame_ready=1 before 2nd tick -> frame_ack pulse, bank_sel 0->1, frame 2 streams bank1 contents; frame_ready=0 before 3rd tick -> bank_sel stays 1.
- Serializer requests 1 cycle apart -> second request ignored, underrun=1 and stays 1 until reset; byte sequence not skipped.
- FRAME_CYCLES=50 with requests every 8 cycles (stream >50) -> tick during STREAM skipped, no trigger, frame_count counts only completed frames.
- enable dropped mid-frame -> frame completes with all 12 bytes, no later trigger; rst_n pulsed mid-stream -> all outputs reset same cycle, no frame_done.
- GLOBAL_DIM_EN, dim=0x7F, byte 0xFF -> ws_byte 0x7F; dim=0xFF -> 0xFF unchanged.
